// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch requester, the load/store requester, the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the combined datapath-and-memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_done;
    logic          i_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          d_stall;

    logic          mem_valid;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_done, i_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_done, d_stall,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_done, i_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_done, d_stall,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Data wins contention; a saturating starvation counter forces a fetch after STARVE_MAX data wins.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          served_d_q, served_d_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;

    logic grant_i;
    logic grant_d;
    logic mem_done;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the values from before the edge regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            served_d_q   <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            served_d_q   <= served_d_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Arbitration happens only in IDLE; RESP ignores requests entirely.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        grant_i = 1'b0;
        grant_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.d_req && !(bus.i_req && starve_cnt_q == STARVE_LIMIT)) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end else if (bus.i_req) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_done = bus.mem_ready && (state_q == BUSY_I || state_q == BUSY_D);

    always_comb begin
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        served_d_d   = served_d_q;
        starve_cnt_d = starve_cnt_q;

        if (grant_i || grant_d) begin
            mem_valid_d = 1'b1;
            mem_we_d    = grant_d && bus.d_we;
            mem_addr_d  = grant_d ? bus.d_addr : bus.i_addr;
            mem_wdata_d = grant_d ? bus.d_wdata : '0;
        end

        // Only a data win over a waiting fetch counts toward starvation.
        if (grant_i) begin
            starve_cnt_d = '0;
        end else if (grant_d) begin
            if (!bus.i_req)                       starve_cnt_d = '0;
            else if (starve_cnt_q != STARVE_LIMIT) starve_cnt_d = starve_cnt_q + CW'(1);
        end

        if (mem_done) begin
            mem_valid_d = 1'b0;
            served_d_d  = (state_q == BUSY_D);
            if (state_q == BUSY_I)            i_rdata_d = bus.mem_rdata;
            if (state_q == BUSY_D && !mem_we_q) d_rdata_d = bus.mem_rdata;
        end
    end

    assign bus.i_done    = (state_q == RESP) && !served_d_q;
    assign bus.d_done    = (state_q == RESP) &&  served_d_q;
    assign bus.i_stall   = bus.i_req && !bus.i_done;
    assign bus.d_stall   = bus.d_req && !bus.d_done;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed fetch/load/store/reset steps, contention and starvation
// sequences, then a randomized mixed-traffic run against a reference memory and arbitration model.
module tb_mem_port_arbiter;
    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
    localparam logic [31:0] IBASE = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Environment: memory responder, two requesters, arbitration model.
    bit          auto_mem, auto_req, grant_model_on;
    int          max_wait, issue_pct, d_we_mode;
    bit          pending;
    int          wait_left;
    logic [31:0] mem_dstore [logic [31:0]];
    logic [31:0] ref_dmem   [logic [31:0]];
    bit          i_out, d_out, d_is_load;
    logic [31:0] i_exp, d_exp, d_last;
    int          i_budget, d_budget, i_reqs, i_dones, d_reqs, d_dones;
    int          m_starve;
    bit          mem_valid_prev;
    int          grant_log[$];
    int          starve_log[$];

    function automatic logic [31:0] ifetch_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0050_0093;
    endfunction

    function automatic logic [31:0] dmem_default(input logic [31:0] a);
        return 32'hA5A5_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_valid"}, 32'(bus.mem_valid), 32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_mem_addr"},  bus.mem_addr,       32'd0);
        check({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
        check({tag, "_i_rdata"},   bus.i_rdata,        32'd0);
        check({tag, "_d_rdata"},   bus.d_rdata,        32'd0);
        check({tag, "_i_done"},    32'(bus.i_done),    32'd0);
        check({tag, "_d_done"},    32'(bus.d_done),    32'd0);
        check({tag, "_starve"},    32'(dut.starve_cnt_q), 32'd0);
    endtask

    // One clock: everything is sampled and driven at the falling edge.
    task automatic step();
        @(negedge clk);
        if (grant_model_on && bus.mem_valid && !mem_valid_prev) begin
            bit exp_d;
            bit got_d;
            exp_d = bus.d_req && !(bus.i_req && m_starve == STARVE_MAX);
            got_d = (bus.mem_addr < IBASE);
            check("grant_port", 32'(got_d), 32'(exp_d));
            check("grant_addr", bus.mem_addr, got_d ? bus.d_addr : bus.i_addr);
            if (exp_d) m_starve = bus.i_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve) : 0;
            else       m_starve = 0;
            check("starve_cnt", 32'(dut.starve_cnt_q), 32'(m_starve));
            grant_log.push_back(int'(got_d));
            starve_log.push_back(int'(dut.starve_cnt_q));
        end
        mem_valid_prev = bus.mem_valid;

        if (bus.i_done || bus.d_done)
            check("done_exclusive", 32'(bus.i_done & bus.d_done), 32'd0);

        if (auto_req) begin
            if (bus.i_done) begin
                check("i_done_owed", 32'(i_out), 32'd1);
                check("i_rdata", bus.i_rdata, i_exp);
                i_out = 1'b0; i_dones++; bus.i_req = 1'b0;
            end
            if (bus.d_done) begin
                check("d_done_owed", 32'(d_out), 32'd1);
                check(d_is_load ? "d_rdata_load" : "d_rdata_hold", bus.d_rdata, d_is_load ? d_exp : d_last);
                if (d_is_load) d_last = d_exp;
                d_out = 1'b0; d_dones++; bus.d_req = 1'b0;
            end
        end

        if (auto_mem) begin
            if (bus.mem_ready) begin
                bus.mem_ready = 1'b0;
            end else if (bus.mem_valid) begin
                if (!pending) begin
                    pending = 1'b1;
                    wait_left = int'($urandom_range(max_wait, 0));
                end
                if (wait_left == 0) begin
                    pending = 1'b0;
                    bus.mem_ready = 1'b1;
                    if (bus.mem_addr >= IBASE) begin
                        bus.mem_rdata = ifetch_word(bus.mem_addr);
                    end else if (bus.mem_we) begin
                        mem_dstore[bus.mem_addr] = bus.mem_wdata;
                        bus.mem_rdata = $urandom;
                    end else begin
                        bus.mem_rdata = mem_dstore.exists(bus.mem_addr) ? mem_dstore[bus.mem_addr]
                                                                        : dmem_default(bus.mem_addr);
                    end
                end else begin
                    wait_left--;
                end
            end
        end

        if (auto_req) begin
            if (!i_out && i_budget > 0 && $urandom_range(99, 0) < issue_pct) begin
                bus.i_addr = IBASE + 32'($urandom_range(255, 0)) * 32'd4;
                i_exp = ifetch_word(bus.i_addr);
                bus.i_req = 1'b1; i_out = 1'b1; i_budget--; i_reqs++;
            end
            if (!d_out && d_budget > 0 && $urandom_range(99, 0) < issue_pct) begin
                d_is_load = (d_we_mode == 2) ? ($urandom_range(1, 0) == 0) : (d_we_mode == 0);
                bus.d_we    = !d_is_load;
                bus.d_addr  = 32'($urandom_range(15, 0)) * 32'd4;
                bus.d_wdata = $urandom;
                if (d_is_load) d_exp = ref_dmem.exists(bus.d_addr) ? ref_dmem[bus.d_addr] : dmem_default(bus.d_addr);
                else           ref_dmem[bus.d_addr] = bus.d_wdata;
                bus.d_req = 1'b1; d_out = 1'b1; d_budget--; d_reqs++;
            end
        end
    endtask

    task automatic run_until_drained(input string tag, input int limit);
        int n = 0;
        while ((i_budget > 0 || d_budget > 0 || i_out || d_out) && n < limit) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 32'(n < limit), 32'd1);
    endtask

    // Hand-driven single transaction with memory answering after `waits` wait cycles.
    task automatic manual_txn(input string tag, input bit is_d, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                              input logic [31:0] d_hold);
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        bus.mem_ready = 1'b0;
        #1;
        check({tag, "_stall_c0"}, 32'(is_d ? bus.d_stall : bus.i_stall), 32'd1);
        step();
        for (int k = 0; k <= waits; k++) begin
            check({tag, "_mem_valid"}, 32'(bus.mem_valid), 32'd1);
            check({tag, "_mem_we"},    32'(bus.mem_we),    32'(we));
            check({tag, "_mem_addr"},  bus.mem_addr,       addr);
            if (we) check({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
            check({tag, "_stall_busy"}, 32'(is_d ? bus.d_stall : bus.i_stall), 32'd1);
            check({tag, "_early_done"}, 32'(is_d ? bus.d_done : bus.i_done), 32'd0);
            if (k == waits) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = rdata;
            end
            step();
        end
        check({tag, "_done"},       32'(is_d ? bus.d_done : bus.i_done), 32'd1);
        check({tag, "_other_done"}, 32'(is_d ? bus.i_done : bus.d_done), 32'd0);
        check({tag, "_stall_done"}, 32'(is_d ? bus.d_stall : bus.i_stall), 32'd0);
        check({tag, "_valid_resp"}, 32'(bus.mem_valid), 32'd0);
        if (!is_d) check({tag, "_rdata"}, bus.i_rdata, rdata);
        else       check({tag, "_rdata"}, bus.d_rdata, we ? d_hold : rdata);
        bus.mem_ready = 1'b0;
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        step();
        check({tag, "_done_pulse"}, 32'(is_d ? bus.d_done : bus.i_done), 32'd0);
    endtask

    task automatic start_auto(input int mw, input int pct, input int wmode, input int ib, input int db);
        auto_mem = 1'b1; auto_req = 1'b1; grant_model_on = 1'b1;
        max_wait = mw; issue_pct = pct; d_we_mode = wmode;
        i_budget = ib; d_budget = db;
        i_reqs = 0; i_dones = 0; d_reqs = 0; d_dones = 0;
        pending = 1'b0; m_starve = 0; mem_valid_prev = bus.mem_valid;
        grant_log.delete(); starve_log.delete();
    endtask

    initial begin
        auto_mem = 1'b0; auto_req = 1'b0; grant_model_on = 1'b0;
        pending = 1'b0; i_out = 1'b0; d_out = 1'b0; d_last = '0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b0;

        repeat (2) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;
        step();

        manual_txn("fetch", 1'b0, 1'b0, 32'h100, 32'h0, 32'h0050_0093, 0, 32'h0);
        manual_txn("load",  1'b1, 1'b0, 32'h24,  32'h0, 32'hCAFE_F00D, 1, 32'h0);
        manual_txn("store", 1'b1, 1'b1, 32'h20,  32'hDEAD_BEEF, 32'h0BAD_F00D, 3, 32'hCAFE_F00D);

        // Reset asserted between clock edges while a load is in BUSY_D.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h30;
        step();
        check("rst_busy_valid", 32'(bus.mem_valid), 32'd1);
        #2 reset = 1'b1;
        #1 check_reset_values("rst_mid");
        bus.d_req = 1'b0;
        step();
        check("rst_no_done", 32'(bus.d_done), 32'd0);
        step();
        reset = 1'b0;
        manual_txn("post_rst_fetch", 1'b0, 1'b0, 32'h200, 32'h0, 32'h0000_0013, 2, 32'h0);
        d_last = '0;

        // Simultaneous requests: data first, then fetch.
        start_auto(0, 100, 0, 1, 1);
        run_until_drained("contend", 100);
        check("contend_grants", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() >= 2) begin
            check("contend_first_data", 32'(grant_log[0]), 32'd1);
            check("contend_then_fetch", 32'(grant_log[1]), 32'd0);
            check("contend_starve_1",   32'(starve_log[0]), 32'd1);
            check("contend_starve_0",   32'(starve_log[1]), 32'd0);
        end

        // Held fetch against back-to-back loads: four data grants, then the fetch.
        start_auto(0, 100, 0, 1, 6);
        run_until_drained("starve", 300);
        check("starve_grants", 32'(grant_log.size()), 32'd7);
        if (grant_log.size() >= 5) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("starve_data_%0d", k), 32'(grant_log[k]), 32'd1);
                check($sformatf("starve_cnt_%0d", k), 32'(starve_log[k]), 32'(k + 1));
            end
            check("starve_forced_fetch", 32'(grant_log[4]), 32'd0);
            check("starve_cleared",      32'(starve_log[4]), 32'd0);
        end

        // Mixed random traffic with 0-7 wait cycles.
        start_auto(7, 40, 2, 100, 100);
        run_until_drained("stress", 20000);
        check("stress_i_reqs",  32'(i_reqs),  32'd100);
        check("stress_d_reqs",  32'(d_reqs),  32'd100);
        check("stress_i_dones", 32'(i_dones), 32'(i_reqs));
        check("stress_d_dones", 32'(d_dones), 32'(d_reqs));

        auto_req = 1'b0;
        repeat (3) step();
        check("final_idle_valid", 32'(bus.mem_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
